// File: rtl/panda_mmio.sv
// panda_mmio: memory-mapped peripheral responder on the core data port.
// Provides a 64-bit machine timer with compare interrupt, a byte console TX FIFO
// and a TOHOST halt/exit-code register. Read timing matches the data RAM: rdata_o
// is registered every edge from addr_i, returning the state before that edge's writes.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   sel_i              decoder hit; qualifies we_i
//   addr_i[4:0]        byte address, bits[4:2] select register
//   wdata_i[31:0]      write data
//   we_i[3:0]          per-byte write enables
//   rdata_o[31:0]      registered read data
//   tx_data_o[7:0]     FIFO head byte
//   tx_valid_o         FIFO not empty
//   tx_ready_i         sink accepts head byte
//   timer_irq_o        registered mtime >= mtimecmp
//   halt_o             sticky halt, set by TOHOST write
//   exit_code_o[30:0]  TOHOST write data[31:1]
module panda_mmio #(
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned TickDiv   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sel_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  we_i,
    output logic [31:0] rdata_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        timer_irq_o,
    output logic        halt_o,
    output logic [30:0] exit_code_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned PreW = (TickDiv > 1) ? $clog2(TickDiv) : 1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    logic [3:0]  wr_lane;
    logic [2:0]  reg_sel;
    logic        mt_lo_wr, mt_hi_wr, cmp_lo_wr, cmp_hi_wr;
    logic        push_req, push_ok, pop, ovf_clr;
    logic        tohost_wr;

    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic            irq_q;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            halt_q, halt_d;
    logic [30:0]     exit_q, exit_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [7:0]      mem_q [FifoDepth];
    logic            fifo_full, fifo_empty;

    assign wr_lane   = sel_i ? we_i : 4'b0000;
    assign reg_sel   = addr_i[4:2];
    assign mt_lo_wr  = (reg_sel == 3'd0) && (|wr_lane);
    assign mt_hi_wr  = (reg_sel == 3'd1) && (|wr_lane);
    assign cmp_lo_wr = (reg_sel == 3'd2) && (|wr_lane);
    assign cmp_hi_wr = (reg_sel == 3'd3) && (|wr_lane);
    assign push_req  = (reg_sel == 3'd4) && wr_lane[0];
    assign ovf_clr   = (reg_sel == 3'd5) && wr_lane[0] && wdata_i[2];
    assign tohost_wr = (reg_sel == 3'd6) && wr_lane[0];

    assign fifo_full  = (count_q == CntW'(FifoDepth));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && tx_ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    // Timer: a write to either MTIME word suppresses the increment and restarts the prescaler.
    always_comb begin
        mtime_d    = mtime_q;
        presc_d    = presc_q;
        mtimecmp_d = mtimecmp_q;
        if (mt_lo_wr || mt_hi_wr) begin
            if (mt_lo_wr) mtime_d[31:0]  = merge_bytes(mtime_q[31:0], wdata_i, wr_lane);
            if (mt_hi_wr) mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_i, wr_lane);
            presc_d = '0;
        end else if (presc_q == PreW'(TickDiv - 1)) begin
            presc_d = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        if (cmp_lo_wr) mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata_i, wr_lane);
        if (cmp_hi_wr) mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_i, wr_lane);
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop)     rptr_d = rptr_q + 1'b1;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
        if (ovf_clr)                   ovf_d = 1'b0;
        else if (push_req && !push_ok) ovf_d = 1'b1;
    end

    always_comb begin
        halt_d = halt_q;
        exit_d = exit_q;
        if (tohost_wr && wdata_i[0] && !halt_q) begin
            halt_d = 1'b1;
            exit_d = wdata_i[31:1];
        end
    end

    // Read-first: every source is the pre-edge register state.
    always_comb begin
        rdata_d = '0;
        case (reg_sel)
            3'd0:    rdata_d = mtime_q[31:0];
            3'd1:    rdata_d = mtime_q[63:32];
            3'd2:    rdata_d = mtimecmp_q[31:0];
            3'd3:    rdata_d = mtimecmp_q[63:32];
            3'd5:    rdata_d = {16'h0, 8'(count_q), 5'h0, ovf_q, fifo_empty, fifo_full};
            3'd6:    rdata_d = {exit_q, halt_q};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            irq_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            halt_q     <= 1'b0;
            exit_q     <= '0;
            rdata_q    <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            halt_q     <= halt_d;
            exit_q     <= exit_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i[7:0];
    end

    assign rdata_o     = rdata_q;
    assign tx_valid_o  = !fifo_empty;
    assign tx_data_o   = fifo_empty ? 8'h00 : mem_q[rptr_q];
    assign timer_irq_o = irq_q;
    assign halt_o      = halt_q;
    assign exit_code_o = exit_q;

endmodule

// File: tb/tb_panda_mmio.sv
module tb_panda_mmio;

    localparam int unsigned FifoDepth = 8;
    localparam logic [4:0] AMtLo  = 5'h00;
    localparam logic [4:0] AMtHi  = 5'h04;
    localparam logic [4:0] ACmpLo = 5'h08;
    localparam logic [4:0] ACmpHi = 5'h0C;
    localparam logic [4:0] ATx    = 5'h10;
    localparam logic [4:0] ASt    = 5'h14;
    localparam logic [4:0] AToh   = 5'h18;
    localparam logic [4:0] ARsv   = 5'h1C;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        sel_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  we_i;
    logic [31:0] rdata_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        timer_irq_o;
    logic        halt_o;
    logic [30:0] exit_code_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] tx_q[$];
    int model_cnt = 0;
    logic model_ovf = 1'b0;

    panda_mmio #(.FifoDepth(FifoDepth), .TickDiv(1)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sel_i      (sel_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .we_i       (we_i),
        .rdata_o    (rdata_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .timer_irq_o(timer_irq_o),
        .halt_o     (halt_o),
        .exit_code_o(exit_code_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk_i);
        sel_i = 1'b1; addr_i = a; wdata_i = d; we_i = be;
        @(posedge clk_i); #1;
        sel_i = 1'b0; we_i = 4'b0000;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk_i);
        addr_i = a;
        @(posedge clk_i); #1;
        d = rdata_o;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            @(posedge clk_i); #1;
        end
    endtask

    // Push with sink stalled: the bench model decides acceptance.
    task automatic push_byte(input logic [7:0] b);
        wr(ATx, {24'h0, b}, 4'b0001);
        if (model_cnt < FifoDepth) begin
            tx_q.push_back(b);
            model_cnt++;
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    function automatic logic [31:0] status_exp();
        logic [31:0] s;
        s = 32'(model_cnt) << 8;
        if (model_ovf) s[2] = 1'b1;
        if (model_cnt == 0) s[1] = 1'b1;
        if (model_cnt == FifoDepth) s[0] = 1'b1;
        return s;
    endfunction

    task automatic drain_fifo(input string name);
        logic [7:0] exp;
        tx_ready_i = 1'b1;
        for (int c = 0; c < 4 * FifoDepth && tx_q.size() > 0; c++) begin
            @(negedge clk_i);
            if (tx_valid_o) begin
                exp = tx_q.pop_front();
                model_cnt--;
                n_checks++;
                if (tx_data_o !== exp) begin
                    n_fail++;
                    $display("FAIL %s_byte: got %02h expected %02h", name, tx_data_o, exp);
                end
            end
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (tx_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d bytes never delivered", name, tx_q.size());
            tx_q.delete();
            model_cnt = 0;
        end
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        n_checks++;
        if (tx_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_empty: tx_valid got %b expected 0", name, tx_valid_o);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_ni = 1'b0; sel_i = 1'b0; addr_i = '0; wdata_i = '0; we_i = '0; tx_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if ({rdata_o, tx_valid_o, tx_data_o, timer_irq_o, halt_o, exit_code_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdata=%h valid=%b data=%h irq=%b halt=%b exit=%h expected all 0",
                     rdata_o, tx_valid_o, tx_data_o, timer_irq_o, halt_o, exit_code_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(9);
        rd(AMtLo, d);
        n_checks++;
        if (d !== 32'd9 && d !== 32'd10) begin
            n_fail++;
            $display("FAIL reset_mtime_lo: got %0d expected 9 or 10", d);
        end
        rd(AMtHi, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mtime_hi: got %h expected 0", d);
        end
        rd(ACmpHi, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_cmp_hi: got %h expected ffffffff", d);
        end
        rd(ASt, d);
        n_checks++;
        if (d !== 32'h0000_0002) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected 00000002", d);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        // Unselected write must be ignored.
        @(negedge clk_i);
        sel_i = 1'b0; addr_i = ACmpLo; wdata_i = 32'h0; we_i = 4'hF;
        @(posedge clk_i); #1;
        we_i = 4'h0;
        rd(ACmpLo, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sel_gate: got %h expected ffffffff", d);
        end
        wr(ACmpLo, 32'h1234_AB00, 4'b0010);
        rd(ACmpLo, d);
        n_checks++;
        if (d !== 32'hFFFF_ABFF) begin
            n_fail++;
            $display("FAIL byte_lane: got %h expected ffffabff", d);
        end
        wr(ACmpLo, 32'hFFFF_FFFF, 4'hF);
        wr(ARsv, 32'hDEAD_BEEF, 4'hF);
        rd(ARsv, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reserved_read: got %h expected 0", d);
        end
    endtask

    task automatic test_mtime_carry();
        logic [31:0] d;
        wr(AMtLo, 32'hFFFF_FFFF, 4'hF);
        wr(AMtHi, 32'h0, 4'hF);
        idle(1);
        rd(AMtHi, d);
        n_checks++;
        if (d !== 32'd1) begin
            n_fail++;
            $display("FAIL mtime_carry_hi: got %h expected 00000001", d);
        end
        rd(AMtLo, d);
        n_checks++;
        if (d !== 32'd1) begin
            n_fail++;
            $display("FAIL mtime_carry_lo: got %h expected 00000001", d);
        end
    endtask

    task automatic test_timer_irq();
        logic exp;
        wr(ACmpLo, 32'd20, 4'hF);
        wr(AMtHi, 32'h0, 4'hF);
        wr(AMtLo, 32'h0, 4'hF);
        wr(ACmpHi, 32'h0, 4'hF);
        n_checks++;
        if (timer_irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_setup: got %b expected 0", timer_irq_o);
        end
        // Before the k-th following edge mtime equals k.
        for (int k = 1; k <= 22; k++) begin
            idle(1);
            exp = (k >= 20);
            n_checks++;
            if (timer_irq_o !== exp) begin
                n_fail++;
                $display("FAIL irq_rise_k%0d: got %b expected %b", k, timer_irq_o, exp);
            end
        end
        wr(ACmpLo, 32'hFFFF_FFFF, 4'hF);
        n_checks++;
        if (timer_irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_lag: got %b expected 1", timer_irq_o);
        end
        idle(1);
        n_checks++;
        if (timer_irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_fall: got %b expected 0", timer_irq_o);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] d;
        logic [31:0] exp;
        tx_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) push_byte(8'h41 + 8'(i));
        n_checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== tx_q[0]) begin
            n_fail++;
            $display("FAIL fifo_head: valid=%b data=%h expected 1/%h", tx_valid_o, tx_data_o, tx_q[0]);
        end
        idle(2);
        n_checks++;
        if (tx_data_o !== tx_q[0]) begin
            n_fail++;
            $display("FAIL fifo_stall_stable: got %h expected %h", tx_data_o, tx_q[0]);
        end
        exp = status_exp();
        rd(ASt, d);
        n_checks++;
        if (d !== exp) begin
            n_fail++;
            $display("FAIL status_full_ovf: got %h expected %h", d, exp);
        end
        drain_fifo("ovf_drain");
        exp = status_exp();
        rd(ASt, d);
        n_checks++;
        if (d !== exp) begin
            n_fail++;
            $display("FAIL status_empty_ovf: got %h expected %h", d, exp);
        end
        wr(ASt, 32'h4, 4'b0001);
        model_ovf = 1'b0;
        exp = status_exp();
        rd(ASt, d);
        n_checks++;
        if (d !== exp) begin
            n_fail++;
            $display("FAIL status_ovf_clear: got %h expected %h", d, exp);
        end
        rd(ATx, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL txdata_read: got %h expected 0", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] exp;
        logic [7:0]  head;
        tx_ready_i = 1'b0;
        for (int i = 0; i < FifoDepth; i++) push_byte(8'h61 + 8'(i));
        // Push into a full FIFO while the head is being popped.
        @(negedge clk_i);
        sel_i = 1'b1; addr_i = ATx; wdata_i = 32'h5A; we_i = 4'b0001; tx_ready_i = 1'b1;
        head = tx_q.pop_front();
        tx_q.push_back(8'h5A);
        n_checks++;
        if (tx_data_o !== head) begin
            n_fail++;
            $display("FAIL b2b_head: got %h expected %h", tx_data_o, head);
        end
        @(posedge clk_i); #1;
        sel_i = 1'b0; we_i = 4'b0000; tx_ready_i = 1'b0;
        exp = status_exp();
        rd(ASt, d);
        n_checks++;
        if (d !== exp) begin
            n_fail++;
            $display("FAIL b2b_status: got %h expected %h", d, exp);
        end
        drain_fifo("b2b_drain");
        // Push into an empty FIFO with the sink ready: visible next cycle, then popped.
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        sel_i = 1'b1; addr_i = ATx; wdata_i = 32'hC3; we_i = 4'b0001;
        @(posedge clk_i); #1;
        sel_i = 1'b0; we_i = 4'b0000;
        n_checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hC3) begin
            n_fail++;
            $display("FAIL empty_push_pop: valid=%b data=%h expected 1/c3", tx_valid_o, tx_data_o);
        end
        idle(1);
        tx_ready_i = 1'b0;
        n_checks++;
        if (tx_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_push_pop_drain: valid=%b expected 0", tx_valid_o);
        end
    endtask

    task automatic test_tohost();
        logic [31:0] d;
        wr(AToh, 32'h10, 4'hF);
        n_checks++;
        if (halt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tohost_bit0_clear: halt got %b expected 0", halt_o);
        end
        wr(AToh, 32'h7, 4'hF);
        n_checks++;
        if (halt_o !== 1'b1 || exit_code_o !== 31'd3) begin
            n_fail++;
            $display("FAIL tohost_halt: halt=%b exit=%0d expected 1/3", halt_o, exit_code_o);
        end
        wr(AToh, 32'h9, 4'hF);
        n_checks++;
        if (halt_o !== 1'b1 || exit_code_o !== 31'd3) begin
            n_fail++;
            $display("FAIL tohost_sticky: halt=%b exit=%0d expected 1/3", halt_o, exit_code_o);
        end
        rd(AToh, d);
        n_checks++;
        if (d !== 32'h7) begin
            n_fail++;
            $display("FAIL tohost_read: got %h expected 00000007", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        tx_ready_i = 1'b0;
        push_byte(8'h11);
        push_byte(8'h22);
        @(negedge clk_i);
        tx_ready_i = 1'b1;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({tx_valid_o, tx_data_o, halt_o, exit_code_o, rdata_o, timer_irq_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b data=%h halt=%b exit=%h rdata=%h irq=%b expected all 0",
                     tx_valid_o, tx_data_o, halt_o, exit_code_o, rdata_o, timer_irq_o);
        end
        tx_q.delete();
        model_cnt = 0;
        model_ovf = 1'b0;
        tx_ready_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        rd(ASt, d);
        n_checks++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL reset_mid_status: got %h expected 00000002", d);
        end
        rd(ACmpLo, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_mid_cmp: got %h expected ffffffff", d);
        end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_mtime_carry();
        test_timer_irq();
        test_fifo_overflow();
        test_back_to_back();
        test_tohost();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
